// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial frame transmitter: SYNC_PAT preamble then DATA_W payload, MSB first
// Optional feature macro TX_PARITY_EN appends one even-parity bit after the payload.
module sync_frame_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int MAXW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CW   = $clog2(MAXW);
    localparam int FW   = SYNC_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
`ifdef TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [FW-1:0]   frame, frame_n;
    logic            dout_n, valid_n, busy_n, done_n, ready_n;
    logic            accept;
`ifdef TX_PARITY_EN
    logic            par, par_n;
`endif

    assign accept = start && ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = frame;
`ifdef TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            SYNC: begin
                frame_n = {frame[FW-2:0], 1'b0};
                if (cnt == CW'(SYNC_W - 1)) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                frame_n = {frame[FW-2:0], 1'b0};
                if (cnt == CW'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = IDLE;
`endif
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase

        // ready is only high in IDLE or the final frame cycle, so accept overrides the IDLE return
        if (accept) begin
            state_n = SYNC;
            cnt_n   = '0;
            frame_n = {SYNC_PAT, data_in};
`ifdef TX_PARITY_EN
            par_n   = ^data_in;
`endif
        end
    end

    // Outputs are registered: decode what the next cycle will show from the next-state values
    always_comb begin
        dout_n  = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        ready_n = 1'b0;
        case (state_n)
            SYNC: begin
                dout_n  = frame_n[FW-1];
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
            DATA: begin
                dout_n  = frame_n[FW-1];
                valid_n = 1'b1;
                busy_n  = 1'b1;
`ifndef TX_PARITY_EN
                done_n  = (cnt_n == CW'(DATA_W - 1));
                ready_n = (cnt_n == CW'(DATA_W - 1));
`endif
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                dout_n  = par_n;
                valid_n = 1'b1;
                busy_n  = 1'b1;
                done_n  = 1'b1;
                ready_n = 1'b1;
            end
`endif
            default: ready_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b1;
`ifdef TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            frame      <= frame_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
            ready      <= ready_n;
`ifdef TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - scoreboard bench for sync_frame_tx (8-bit payload, 1011 preamble)
module tb_sync_frame_tx;

`ifdef TX_PARITY_EN
    localparam int F = 13;
`else
    localparam int F = 12;
`endif

    typedef struct packed {
        logic dout;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, dout, dout_valid, busy, done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    logic mon_en = 1'b0;

    sync_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void check(input logic act, input logic req, input string name);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endfunction

    // bits: expected 12-bit frame (preamble + payload), par: expected parity bit
    task automatic push_frame(input logic [11:0] bits, input logic par);
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.dout = bits[11-i];
`ifdef TX_PARITY_EN
            e.done = 1'b0;
`else
            e.done = (i == 11);
`endif
            exp_q.push_back(e);
        end
`ifdef TX_PARITY_EN
        e.dout = par;
        e.done = 1'b1;
        exp_q.push_back(e);
`else
        if (par) e.dout = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit at %0t: got dout_valid=1 expected 0", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(dout, e.dout, "dout");
                    check(done, e.done, "done");
                    check(ready, e.done, "ready_frame");
                    check(busy, 1'b1, "busy_frame");
                    if (done) done_seen++;
                end
            end else begin
                check(dout, 1'b0, "idle_dout");
                check(done, 1'b0, "idle_done");
                check(busy, 1'b0, "idle_busy");
                check(ready, 1'b1, "idle_ready");
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [11:0] bits, input logic par);
        start   = 1'b1;
        data_in = d;
        push_frame(bits, par);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        // Test 1: reset held with start high
        rst   = 1'b0;
        start = 1'b1;
        data_in = 8'hA5;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Test 2: single frame A5
        send(8'hA5, 12'b1011_1010_0101, 1'b0);
        repeat (F) @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        // Test 3: back-to-back 3C then FF with start held
        start   = 1'b1;
        data_in = 8'h3C;
        push_frame(12'b1011_0011_1100, 1'b0);
        push_frame(12'b1011_1111_1111, 1'b0);
        @(posedge clk);
        #1 data_in = 8'hFF;
        repeat (F) @(posedge clk);
        #1 start = 1'b0;
        data_in = 8'h00;
        repeat (F - 1) @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        // Test 4: start pulse in cycle 5 of a frame is ignored
        send(8'hA5, 12'b1011_1010_0101, 1'b0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        data_in = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        data_in = 8'hA5;
        repeat (F - 5) @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;

        // Test 5: reset in cycle 7 abandons the frame
        send(8'hA5, 12'b1011_1010_0101, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 exp_q.delete();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_bits: got %0d expected 0", exp_q.size());
        end
        checks++;
        if (done_seen != 4) begin
            errors++;
            $display("FAIL done_pulses: got %0d expected 4", done_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
